// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1331 OLED pixel streaming path:
// panel geometry, RGB565 field layout, scanner FSM encoding and the
// CRC-16/CCITT constants with a single-bit update helper.
package oled_pkg;

    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;

    localparam int PIXEL_BITS   = 16;
    localparam int RGB_R_WIDTH  = 5;
    localparam int RGB_G_WIDTH  = 6;
    localparam int RGB_B_WIDTH  = 5;
    localparam int RGB_R_OFFSET = 11;
    localparam int RGB_G_OFFSET = 5;
    localparam int RGB_B_OFFSET = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } scan_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first CRC-16/CCITT step for a single incoming bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic feedback;
        feedback = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/oled_crc16_serial.sv
// Bit-serial CRC-16/CCITT accumulator (poly 0x1021, no reflection).
// init_i reloads the seed; en_i folds in one data bit per clock.
module oled_crc16_serial
    import oled_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic        init_i,
    input  logic        data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Seed on init, otherwise fold in the current bit when enabled.
    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, data_i);
        end
    end

    // Running CRC register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/oled_pixel_scanner.sv
// Raster scanner for the 96x64 SSD1331: requests each pixel colour by
// coordinate, waits out the colour generator latency, then shifts the
// RGB565 word MSB-first on a clk/2 SPI mode-0 link with DC held high.
// Optional feature macro: FRAME_CRC_EN adds a frame_crc output carrying
// the CRC-16/CCITT of every bit streamed in the last completed frame.
module oled_pixel_scanner
    import oled_pkg::*;
#(
    parameter int WIDTH         = OLED_WIDTH,
    parameter int HEIGHT        = OLED_HEIGHT,
    parameter int COLOR_LATENCY = 1
)
(
    input  logic        clk12p5mhz_clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        frame_start,
    input  logic [15:0] pixel_color,
    output logic [7:0]  coordinate_x,
    output logic [6:0]  coordinate_y,
    output logic        oled_cs_n,
    output logic        oled_dc,
    output logic        oled_sclk,
    output logic        oled_mosi,
    output logic        busy,
    output logic        frame_done
`ifdef FRAME_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    scan_state_e state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  wait_q, wait_d;
    logic [4:0]  phase_q, phase_d;
    logic [15:0] shift_q, shift_d;

    logic last_pixel;
    logic last_wait;
    logic last_phase;
    logic accept;

    assign last_pixel = (x_q == 8'(WIDTH - 1)) && (y_q == 7'(HEIGHT - 1));
    assign last_wait  = (wait_q == 3'(COLOR_LATENCY - 1));
    assign last_phase = (phase_q == 5'd31);
    assign accept     = (state_q == IDLE) && frame_start && init_done;

    // State and datapath registers; reset returns everything to idle.
    always_ff @(posedge clk12p5mhz_clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            wait_q  <= '0;
            phase_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wait_q  <= wait_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: sequencing, coordinate stepping and bit shifting.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        wait_d  = wait_q;
        phase_d = phase_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            REQ: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                if (last_wait) begin
                    state_d = SHIFT;
                    wait_d  = '0;
                    phase_d = '0;
                    shift_d = pixel_color;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            SHIFT: begin
                phase_d = phase_q + 5'd1;
                if (phase_q[0]) begin
                    shift_d = {shift_q[14:0], 1'b0};
                end
                if (last_phase) begin
                    phase_d = '0;
                    if (last_pixel) begin
                        state_d = DONE;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        state_d = REQ;
                        if (x_q == 8'(WIDTH - 1)) begin
                            x_d = '0;
                            y_d = y_q + 7'd1;
                        end else begin
                            x_d = x_q + 8'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((state_q != IDLE) && !init_done) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            wait_d  = '0;
            phase_d = '0;
            shift_d = '0;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        logic streaming;
        streaming    = (state_q == REQ) || (state_q == WAIT) || (state_q == SHIFT);
        busy         = streaming;
        oled_cs_n    = !streaming;
        oled_dc      = streaming;
        oled_sclk    = (state_q == SHIFT) && phase_q[0];
        oled_mosi    = (state_q == SHIFT) && shift_q[15];
        frame_done   = (state_q == DONE);
        coordinate_x = x_q;
        coordinate_y = y_q;
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crc_running;
    logic [15:0] frame_crc_q;

    oled_crc16_serial u_crc (
        .clk_i   (clk12p5mhz_clk),
        .reset_i (reset),
        .en_i    ((state_q == SHIFT) && !phase_q[0]),
        .init_i  (accept),
        .data_i  (shift_q[15]),
        .crc_o   (crc_running)
    );

    // Capture the finished CRC on the edge that enters DONE; aborts skip it.
    always_ff @(posedge clk12p5mhz_clk) begin
        if (reset) begin
            frame_crc_q <= '0;
        end else if (state_d == DONE) begin
            frame_crc_q <= crc_running;
        end
    end

    assign frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_oled_pixel_scanner.sv
// Self-checking bench for oled_pixel_scanner. Two instances share reset and
// init_done: A runs at colour latency 1, B at latency 3. Both use a reduced
// 96x4 frame so full frames stay short while still exercising row wrap.
// Define FRAME_CRC_EN to also check frame_crc.
module tb_oled_pixel_scanner;

   localparam int W     = 96;
   localparam int H     = 4;
   localparam int NPIX  = W * H;
   localparam int CYC_A = 34;
   localparam int CYC_B = 36;

   logic clk = 1'b0;
   logic reset, initDone, frameStartA, frameStartB, constMode;
   logic [15:0] pixelColorA, pixelColorB, genA, genB1, genB2, genB3;
   logic [7:0] xA, xB;
   logic [6:0] yA, yB;
   logic csnA, dcA, sclkA, mosiA, busyA, doneA;
   logic csnB, dcB, sclkB, mosiB, busyB, doneB;
`ifdef FRAME_CRC_EN
   logic [15:0] crcA, crcB;
`endif

   int checks = 0;
   int errors = 0;
   int cycleCnt = 0;

   // 12.5 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used for latency and period measurements.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   function automatic logic [15:0] pixFn(input logic [7:0] x, input logic [6:0] y);
      return {x[4:0], y[5:0], x[4:0]};
   endfunction

   function automatic logic [15:0] expPix(input int k);
      logic [7:0] x;
      logic [6:0] y;
      x = 8'(k % W);
      y = 7'(k / W);
      return pixFn(x, y);
   endfunction

   function automatic logic [15:0] crcWord(input logic [15:0] crcIn, input logic [15:0] w);
      logic [15:0] c;
      c = crcIn;
      for (int b = 15; b >= 0; b--) begin
         if (c[15] ^ w[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // Colour generator models: registered lookup, plus two extra stages for B.
   always @(posedge clk) begin
      genA  <= pixFn(xA, yA);
      genB1 <= pixFn(xB, yB);
      genB2 <= genB1;
      genB3 <= genB2;
   end

   assign pixelColorA = constMode ? 16'hF800 : genA;
   assign pixelColorB = genB3;

   oled_pixel_scanner #(.WIDTH(W), .HEIGHT(H), .COLOR_LATENCY(1)) dutA (
      .clk12p5mhz_clk (clk),
      .reset          (reset),
      .init_done      (initDone),
      .frame_start    (frameStartA),
      .pixel_color    (pixelColorA),
      .coordinate_x   (xA),
      .coordinate_y   (yA),
      .oled_cs_n      (csnA),
      .oled_dc        (dcA),
      .oled_sclk      (sclkA),
      .oled_mosi      (mosiA),
      .busy           (busyA),
      .frame_done     (doneA)
`ifdef FRAME_CRC_EN
      ,
      .frame_crc      (crcA)
`endif
   );

   oled_pixel_scanner #(.WIDTH(W), .HEIGHT(H), .COLOR_LATENCY(3)) dutB (
      .clk12p5mhz_clk (clk),
      .reset          (reset),
      .init_done      (initDone),
      .frame_start    (frameStartB),
      .pixel_color    (pixelColorB),
      .coordinate_x   (xB),
      .coordinate_y   (yB),
      .oled_cs_n      (csnB),
      .oled_dc        (dcB),
      .oled_sclk      (sclkB),
      .oled_mosi      (mosiB),
      .busy           (busyB),
      .frame_done     (doneB)
`ifdef FRAME_CRC_EN
      ,
      .frame_crc      (crcB)
`endif
   );

   logic sclkPrev [2] = '{1'b0, 1'b0};
   int bitCnt [2] = '{0, 0};
   logic [15:0] word [2] = '{16'h0, 16'h0};
   int sclkRises [2] = '{0, 0};
   int doneCount [2] = '{0, 0};
   logic [15:0] pixQA[$], pixQB[$];
   int cycQA[$], cycQB[$];
   logic [7:0] prevX = 8'd0;
   logic [6:0] prevY = 7'd0;
   int wrapSeen = 0;
   int wrapBad = 0;

   // Serial receiver: rebuilds pixel words from SPI rising edges on both links
   // and watches instance A's coordinates for row-wrap behaviour.
   always @(negedge clk) begin : monitor
      logic s, m, c, d;
      for (int i = 0; i < 2; i++) begin
         s = (i == 0) ? sclkA : sclkB;
         m = (i == 0) ? mosiA : mosiB;
         c = (i == 0) ? csnA : csnB;
         d = (i == 0) ? doneA : doneB;
         if (s && !sclkPrev[i]) sclkRises[i]++;
         if (c) begin
            bitCnt[i] = 0;
         end else if (s && !sclkPrev[i]) begin
            if (bitCnt[i] == 0) begin
               if (i == 0) cycQA.push_back(cycleCnt);
               else        cycQB.push_back(cycleCnt);
            end
            word[i] = {word[i][14:0], m};
            bitCnt[i]++;
            if (bitCnt[i] == 16) begin
               if (i == 0) pixQA.push_back(word[i]);
               else        pixQB.push_back(word[i]);
               bitCnt[i] = 0;
            end
         end
         if (d) doneCount[i]++;
         sclkPrev[i] = s;
      end
      if (prevX == 8'd95 && xA == 8'd0 && yA != 7'd0) begin
         wrapSeen++;
         if (yA != prevY + 7'd1) wrapBad++;
      end else if (yA != prevY && yA != 7'd0) begin
         wrapBad++;
      end
      prevX = xA;
      prevY = yA;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic init, input logic start);
      reset       = rst;
      initDone    = init;
      frameStartA = start;
      @(posedge clk);
      #1;
   endtask

   task automatic waitDone(input int which, input int limit, output logic seen);
      int n;
      n = 0;
      while (((which == 0) ? doneA : doneB) !== 1'b1 && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      seen = ((which == 0) ? doneA : doneB) === 1'b1;
   endtask

   typedef struct packed {
      logic rst; logic init; logic start;
      logic csN; logic dc; logic busy; logic sclk; logic mosi; logic done;
      logic [7:0] x; logic [6:0] y;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int startCycle, baseA, baseB, snapDone, snapRise, bad, n;
      logic seen, reached;
      logic [15:0] goldCrc, savedCrc;

      // {rst,init,start}, {csN,dc,busy,sclk,mosi,done}, x, y
      vecs[0] = {3'b100, 6'b100000, 8'd0, 7'd0};
      vecs[1] = {3'b001, 6'b100000, 8'd0, 7'd0};
      vecs[2] = {3'b010, 6'b100000, 8'd0, 7'd0};
      vecs[3] = {3'b011, 6'b011000, 8'd0, 7'd0};
      vecs[4] = {3'b010, 6'b011000, 8'd0, 7'd0};
      vecs[5] = {3'b010, 6'b011000, 8'd0, 7'd0};
      vecs[6] = {3'b010, 6'b011100, 8'd0, 7'd0};
      vecs[7] = {3'b010, 6'b011000, 8'd0, 7'd0};
      vecs[8] = {3'b011, 6'b011100, 8'd0, 7'd0};
      vecs[9] = {3'b010, 6'b011000, 8'd0, 7'd0};

      reset = 1'b1; initDone = 1'b0; frameStartA = 1'b0; frameStartB = 1'b0; constMode = 1'b0;
      startCycle = 0;
      #1;

      $display("[TB] reset, start gating and first shift cycles");
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].start && vecs[i].init && !vecs[i].rst && busyA === 1'b0) startCycle = cycleCnt;
         applyStimulus(vecs[i].rst, vecs[i].init, vecs[i].start);
         checkOutput($sformatf("vec%0d", i),
                     32'({csnA, dcA, busyA, sclkA, mosiA, doneA, xA, yA}),
                     32'({vecs[i].csN, vecs[i].dc, vecs[i].busy, vecs[i].sclk, vecs[i].mosi, vecs[i].done, vecs[i].x, vecs[i].y}));
      end
`ifdef FRAME_CRC_EN
      checkOutput("crcAfterReset", 32'(crcA), 32'h0);
`endif

      $display("[TB] full frame on instance A");
      waitDone(0, NPIX * CYC_A + 100, seen);
      checkOutput("frameDoneSeen", 32'(seen), 32'd1);
      checkOutput("frameDoneCycle", 32'(cycleCnt - startCycle), 32'(NPIX * CYC_A + 1));
      checkOutput("busyLowAtDone", 32'({busyA, csnA, dcA}), 32'b010);
      checkOutput("pixelCount", 32'(pixQA.size()), 32'(NPIX));
      checkOutput("pixel0", 32'(pixQA[0]), 32'h0000);
      checkOutput("pixel1", 32'(pixQA[1]), 32'h0801);
      checkOutput("pixel95", 32'(pixQA[95]), 32'(expPix(95)));
      checkOutput("pixel96", 32'(pixQA[96]), 32'(expPix(96)));
      checkOutput("pixelLast", 32'(pixQA[NPIX - 1]), 32'(expPix(NPIX - 1)));
      bad = 0;
      for (int k = 0; k < NPIX && k < pixQA.size(); k++) if (pixQA[k] !== expPix(k)) bad++;
      checkOutput("allPixelsA", 32'(bad), 32'd0);
      checkOutput("sclkPulsesA", 32'(sclkRises[0]), 32'(NPIX * 16));
      checkOutput("rowWrapCount", 32'(wrapSeen), 32'(H - 1));
      checkOutput("rowWrapBad", 32'(wrapBad), 32'd0);
      checkOutput("pixelPeriodA", 32'(cycQA[1] - cycQA[0]), 32'(CYC_A));
`ifdef FRAME_CRC_EN
      goldCrc = 16'hFFFF;
      for (int k = 0; k < NPIX; k++) goldCrc = crcWord(goldCrc, expPix(k));
      checkOutput("frameCrcA", 32'(crcA), 32'(goldCrc));
`endif

      $display("[TB] frame_start during DONE is ignored");
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("doneSinglePulse", 32'({doneA, busyA}), 32'b00);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("noRequeue", 32'({busyA, csnA, 8'(pixQA.size() - NPIX)}), 32'({1'b0, 1'b1, 8'd0}));
      checkOutput("doneCountA", 32'(doneCount[0]), 32'd1);

      $display("[TB] abort mid-shift at pixel 100");
      snapDone = doneCount[0];
      baseA = pixQA.size();
`ifdef FRAME_CRC_EN
      savedCrc = crcA;
`endif
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      n = 0;
      while (!(pixQA.size() - baseA == 100 && bitCnt[0] == 5) && n < 200 * CYC_A) begin
         @(posedge clk);
         #1;
         n++;
      end
      reached = (pixQA.size() - baseA == 100) && (bitCnt[0] == 5);
      checkOutput("reachPixel100", 32'({reached, busyA}), 32'b11);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("abortOutputs", 32'({csnA, sclkA, busyA, dcA, xA, yA}), 32'({4'b1000, 8'd0, 7'd0}));
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("noDoneOnAbort", 32'(doneCount[0] - snapDone), 32'd0);
`ifdef FRAME_CRC_EN
      checkOutput("crcHeldOnAbort", 32'(crcA), 32'(savedCrc));
`endif

      $display("[TB] restart after abort");
      baseA = pixQA.size();
      startCycle = cycleCnt;
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitDone(0, NPIX * CYC_A + 100, seen);
      checkOutput("restartDoneCycle", 32'({seen, 24'(cycleCnt - startCycle)}), 32'({1'b1, 24'(NPIX * CYC_A + 1)}));
      checkOutput("restartCount", 32'(pixQA.size() - baseA), 32'(NPIX));
      checkOutput("restartPixel1", 32'(pixQA[baseA + 1]), 32'h0801);
      applyStimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] colour latency 3 on instance B");
      snapRise = sclkRises[1];
      baseB = pixQB.size();
      startCycle = cycleCnt;
      frameStartB = 1'b1;
      @(posedge clk);
      #1;
      frameStartB = 1'b0;
      checkOutput("busyB", 32'({busyB, csnB, dcB}), 32'b101);
      waitDone(1, NPIX * CYC_B + 100, seen);
      checkOutput("frameDoneCycleB", 32'({seen, 24'(cycleCnt - startCycle)}), 32'({1'b1, 24'(NPIX * CYC_B + 1)}));
      checkOutput("pixelCountB", 32'(pixQB.size() - baseB), 32'(NPIX));
      checkOutput("pixelPeriodB", 32'(cycQB[baseB + 1] - cycQB[baseB]), 32'(CYC_B));
      checkOutput("pixel1B", 32'(pixQB[baseB + 1]), 32'h0801);
      bad = 0;
      for (int k = 0; k < NPIX && baseB + k < pixQB.size(); k++) if (pixQB[baseB + k] !== expPix(k)) bad++;
      checkOutput("allPixelsB", 32'(bad), 32'd0);
      checkOutput("sclkPulsesB", 32'(sclkRises[1] - snapRise), 32'(NPIX * 16));

`ifdef FRAME_CRC_EN
      $display("[TB] constant colour 0xF800 frame CRC");
      constMode = 1'b1;
      baseA = pixQA.size();
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitDone(0, NPIX * CYC_A + 100, seen);
      goldCrc = 16'hFFFF;
      for (int k = 0; k < NPIX; k++) goldCrc = crcWord(goldCrc, 16'hF800);
      checkOutput("constCrc", 32'({seen, crcA}), 32'({1'b1, goldCrc}));
      bad = 0;
      for (int k = baseA; k < pixQA.size(); k++) if (pixQA[k] !== 16'hF800) bad++;
      checkOutput("constPixels", 32'({bad[15:0], 16'(pixQA.size() - baseA)}), 32'({16'd0, 16'(NPIX)}));
      constMode = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
